// File: rtl/clk_div_phase_det.sv
// clk_div_phase_det: fast-domain phase recovery for a BUFGCE-divided clock.
// Locks on a stable divided period and strobes ce_o on each divided edge.
module clk_div_phase_det #(
    parameter int  DIV      = 2,
    parameter int  LOCK_CNT = 4,
    localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          div_tgl_i,
    output logic          ce_o,
    output logic [CW-1:0] phase_o,
    output logic          locked_o,
    output logic          err_o,
    output logic [7:0]    err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [3:0]    GOOD_TGT = 4'(LOCK_CNT);

    state_t        state_q;
    logic          tgl_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    good_q;
    logic [3:0]    good_inc;
    logic          ce_q;
    logic          locked_q;
    logic          err_q;
    logic [7:0]    err_cnt_q;

    logic          edge_det;
    logic          at_max;
    logic          match;
    logic          early;
    logic          miss;
    logic          enter_lock;
    logic          lose_lock;

    // Divided-edge detection and period classification against cnt_q
    always_comb begin
        edge_det = div_tgl_i ^ tgl_q;
        at_max   = (cnt_q == CNT_MAX);
        match    = edge_det && at_max;
        early    = edge_det && !at_max;
        miss     = !edge_det && at_max;
        good_inc = good_q + 4'd1;
        enter_lock = (state_q == ACQ) && match
                     && (good_inc == GOOD_TGT);
        lose_lock  = (state_q == LOCK) && (early || miss);
        if (edge_det) begin
            cnt_d = '0;
        end else if (at_max) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Toggle history and fast-cycle phase counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            tgl_q <= div_tgl_i;
            cnt_q <= cnt_d;
        end
    end

    // Lock FSM with registered strobe, lock and error outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            good_q    <= 4'd0;
            ce_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            ce_q     <= match && ((state_q == LOCK) || enter_lock);
            locked_q <= enter_lock
                        || ((state_q == LOCK) && !lose_lock);
            err_q    <= lose_lock;
            if (lose_lock && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (edge_det) begin
                        state_q <= ACQ;
                        good_q  <= 4'd0;
                    end
                end
                ACQ: begin
                    if (match) begin
                        good_q <= good_inc;
                        if (enter_lock) begin
                            state_q <= LOCK;
                        end
                    end else if (early) begin
                        good_q <= 4'd0;
                    end else if (miss) begin
                        state_q <= IDLE;
                        good_q  <= 4'd0;
                    end
                end
                LOCK: begin
                    if (early) begin
                        state_q <= ACQ;
                        good_q  <= 4'd0;
                    end else if (miss) begin
                        state_q <= IDLE;
                        good_q  <= 4'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    good_q  <= 4'd0;
                end
            endcase
        end
    end

    assign ce_o      = ce_q;
    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign phase_o   = locked_q ? cnt_q : '0;

endmodule
